// File: rtl/route_input_ctrl_if.sv
// Handshake bundle between the input FIFO / output arbiters and route_input_ctrl.
// master = the routing controller, slave = FIFO, arbiters and crossbar side.
interface route_input_ctrl_if #(
    parameter int unsigned DATA_WIDTH   = 70,
    parameter int unsigned NUM_CHANNELS = 5
);
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_rok;
    logic                    in_rd;
    logic [NUM_CHANNELS-1:0] req;
    logic [NUM_CHANNELS-1:0] gnt;
    logic                    out_rdy;

    modport master (
        input  in_data, in_rok, gnt, out_rdy,
        output in_rd, req
    );

    modport slave (
        output in_data, in_rok, gnt, out_rdy,
        input  in_rd, req
    );
endinterface

// File: rtl/route_input_ctrl.sv
// Per-input-port route decode and packet flow control for the hierarchical router.
// Define ROUTE_UPLINK_RR_EN to rotate uplink packets round-robin over all uplinks.
module route_input_ctrl #(
    parameter int unsigned DATA_WIDTH   = 70,
    parameter int unsigned NUM_CHANNELS = 5,
    parameter int unsigned NUM_UP       = 1,
    parameter int unsigned ADDR_W       = 22,
    parameter int unsigned CAB_W        = 8,
    parameter int unsigned SLOT_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    route_input_ctrl_if.master     bus,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_local_addr,
    input  logic                   cfg_top,
    input  logic [CAB_W-1:0]       cfg_cab_id,
    output logic [15:0]            drop_cnt
);
    localparam int unsigned NUM_DOWN = NUM_CHANNELS - 1 - NUM_UP;
    localparam int unsigned CH_W     = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

    state_t                  state_q;
    logic [NUM_CHANNELS-1:0] req_q;
    logic [CH_W-1:0]         ch_q;
    logic [15:0]             drop_q;
    logic [ADDR_W-1:0]       local_addr_q;
    logic                    top_q;
    logic [CAB_W-1:0]        cab_id_q;

    logic                    bop, eop;
    logic [ADDR_W-1:0]       dest;
    logic [CAB_W-1:0]        dest_cab;
    logic [SLOT_W-1:0]       dest_slot;
    logic                    route_valid;
    logic                    route_up;
    logic [CH_W-1:0]         route_ch;
    logic [CH_W-1:0]         up_ch;
    logic                    pop;
    logic                    unused_payload;

    assign bop       = bus.in_data[DATA_WIDTH-1];
    assign eop       = bus.in_data[DATA_WIDTH-2];
    assign dest      = bus.in_data[DATA_WIDTH-3 -: ADDR_W];
    assign dest_cab  = dest[ADDR_W-1 -: CAB_W];
    assign dest_slot = dest[ADDR_W-1-CAB_W -: SLOT_W];
    assign unused_payload = ^bus.in_data[DATA_WIDTH-3-ADDR_W:0];

`ifdef ROUTE_UPLINK_RR_EN
    localparam int unsigned UP_W = (NUM_UP > 1) ? $clog2(NUM_UP) : 1;
    logic [UP_W-1:0] up_ptr_q;
    assign up_ch = CH_W'(NUM_DOWN) + CH_W'(up_ptr_q);
`else
    assign up_ch = CH_W'(NUM_DOWN);
`endif

    // Priority: local address, then tier-specific down route, then uplink.
    always_comb begin
        route_valid = 1'b0;
        route_up    = 1'b0;
        route_ch    = '0;
        if (dest == local_addr_q) begin
            route_valid = 1'b1;
            route_ch    = CH_W'(NUM_CHANNELS - 1);
        end else if (top_q) begin
            if (32'(dest_cab) < NUM_DOWN) begin
                route_valid = 1'b1;
                route_ch    = CH_W'(dest_cab);
            end
        end else if (dest_cab == cab_id_q) begin
            if (32'(dest_slot) < NUM_DOWN) begin
                route_valid = 1'b1;
                route_ch    = CH_W'(dest_slot);
            end
        end else begin
            route_valid = 1'b1;
            route_up    = 1'b1;
            route_ch    = up_ch;
        end
    end

    // Pop is combinational so XFER can stream one flit per cycle.
    always_comb begin
        pop = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    pop = bus.in_rok & ~bop;
                XFER:    pop = bus.in_rok & bus.out_rdy & bus.gnt[ch_q];
                DROP:    pop = bus.in_rok;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            ch_q         <= '0;
            drop_q       <= '0;
            local_addr_q <= '0;
            top_q        <= 1'b0;
            cab_id_q     <= '0;
`ifdef ROUTE_UPLINK_RR_EN
            up_ptr_q     <= '0;
`endif
        end else begin
            if (cfg_we) begin
                local_addr_q <= cfg_local_addr;
                top_q        <= cfg_top;
                cab_id_q     <= cfg_cab_id;
            end
            case (state_q)
                IDLE: begin
                    if (bus.in_rok) begin
                        if (bop && route_valid) begin
                            req_q   <= NUM_CHANNELS'(1) << route_ch;
                            ch_q    <= route_ch;
                            state_q <= REQ;
`ifdef ROUTE_UPLINK_RR_EN
                            if (route_up)
                                up_ptr_q <= (32'(up_ptr_q) == NUM_UP - 1) ? '0 : up_ptr_q + 1'b1;
`endif
                        end else begin
                            if (drop_q != '1)
                                drop_q <= drop_q + 16'd1;
                            if (bop)
                                state_q <= DROP;
                        end
                    end
                end
                REQ: begin
                    if (bus.gnt[ch_q])
                        state_q <= XFER;
                end
                XFER: begin
                    if (pop && eop) begin
                        req_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (pop && eop)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef ROUTE_UPLINK_RR_EN
    logic unused_route_up;
    assign unused_route_up = route_up;
`endif

    assign bus.req   = req_q;
    assign bus.in_rd = pop;
    assign drop_cnt  = drop_q;
endmodule

// File: doc/route_input_ctrl.md
Name: route_input_ctrl

Overview:
- Per-input-port routing and flow controller for the hierarchical AXI router.
- Sits between an input flit FIFO and the per-output arbiters.
- Decodes the head-flit destination against runtime tier configuration and raises a one-hot request to one output channel.
- Holds the request for the whole packet while popping flits under grant/ready; discards unroutable packets and stray body flits, and counts them.

Parameters:
DATA_WIDTH, 70, flit width; bit DATA_WIDTH-1 = bop, bit DATA_WIDTH-2 = eop
NUM_CHANNELS, 5, output channels; channel NUM_CHANNELS-1 = local port
NUM_UP, 1, uplink channels, >=1; NUM_DOWN = NUM_CHANNELS-1-NUM_UP (localparam)
ADDR_W, 22, destination address field width, at flit[DATA_WIDTH-3 -: ADDR_W]
CAB_W, 8, cabinet id field = addr[ADDR_W-1 -: CAB_W]
SLOT_W, 4, slot field = addr[ADDR_W-1-CAB_W -: SLOT_W]

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  head flit of input FIFO
in_rok  in  1  FIFO not empty; in_data valid
in_rd  out  1  pop strobe; a flit transfers in any cycle in_rd=1
req  out  NUM_CHANNELS  one-hot output request, registered
gnt  in  NUM_CHANNELS  grants from output arbiters
out_rdy  in  1  crossbar/downstream can accept a flit this cycle
cfg_we  in  1  configuration write strobe
cfg_local_addr  in  ADDR_W  this node's address
cfg_top  in  1  1 = top-tier switch
cfg_cab_id  in  CAB_W  this switch's cabinet id
drop_cnt  out  16  saturating count of discarded packets/stray flits

Behaviour:
- Reset values:
  - state=IDLE, req=0, in_rd=0, drop_cnt=0.
  - cfg registers: local_addr=0, top=0, cab_id=0.
  - Reset mid-packet: return to IDLE immediately; no flit popped that cycle.
- Config: cfg_we=1 registers all three cfg fields on that edge. A route decision uses register values as of its decision cycle.
- Route function, on dest = in_data[DATA_WIDTH-3 -: ADDR_W], first match wins:
  - dest==local_addr -> channel NUM_CHANNELS-1.
  - top=1: cabinet c < NUM_DOWN -> channel c; else invalid.
  - top=0, dest cab==cab_id: slot s < NUM_DOWN -> channel s; else invalid.
  - top=0, other cabinet -> uplink channel NUM_DOWN.
- FSM states: IDLE, REQ, XFER, DROP.
  - IDLE, in_rok=1, bop=1, valid route: req <= onehot(ch) -> REQ. req is visible 1 cycle after the head appears.
  - IDLE, in_rok=1, bop=1, invalid route -> DROP; drop_cnt+1.
  - IDLE, in_rok=1, bop=0 (stray flit): in_rd=1 for that cycle; drop_cnt+1; stay IDLE.
  - REQ: req held; gnt[ch]=1 -> XFER. No pop in REQ.
  - XFER: in_rd = in_rok & out_rdy & gnt[ch], combinational. If the popped flit has eop=1 -> IDLE, and req=0 on the next cycle. Loss of gnt pauses transfer; req stays asserted.
  - DROP: in_rd = in_rok; req=0; the popped flit with eop=1 -> IDLE.
- Single-flit packet (bop=eop=1) is handled as above, with one pop.
- Throughput:
  - Back-to-back packets: minimum 1 IDLE cycle between the eop pop and the next req.
  - XFER sustains 1 flit/cycle.
- req is never multi-hot; it is never nonzero outside REQ/XFER.
- drop_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro ROUTE_UPLINK_RR_EN.
- Defined: uplink-bound packets rotate round-robin over channels NUM_DOWN..NUM_DOWN+NUM_UP-1.
  - Pointer advances once per packet, on IDLE->REQ with an uplink route.
  - Pointer resets to 0 (channel NUM_DOWN).
- Undefined: every uplink packet uses channel NUM_DOWN; no pointer logic.

Test Plan:
Default params (NUM_DOWN=3, uplink=3, local=4); cfg top=0, cab_id=8'h05, local_addr=22'h0A5A5.
- Local: head dest=22'h0A5A5, 3-flit packet, gnt[4]=1, out_rdy=1 -> req=5'b10000 one cycle after rok; 3 consecutive in_rd; req=0 one cycle after the eop pop.
- Down: dest cab=8'h05, slot=4'h2 -> req=5'b00100. Hold gnt=0 for 4 cycles -> no in_rd. Then gnt[2]=1 with out_rdy toggling 1/0 -> in_rd only in out_rdy=1 cycles.
- Up: dest cab=8'h09 -> req=5'b01000. Set cfg_top=1 with dest cab=8'h01 -> req=5'b00010.
- Drop: dest cab=8'h05, slot=4'h7, 2 flits -> req stays 0; 2 pops; drop_cnt=1. Then a stray bop=0 flit in IDLE -> popped; drop_cnt=2.
- Reset mid-XFER after flit 1 of 4 -> req=0, in_rd=0, state IDLE. The remaining body flit at the FIFO head is then dropped as stray (drop_cnt=1).
- ROUTE_UPLINK_RR_EN with NUM_CHANNELS=6, NUM_UP=2: three uplink packets -> req=6'b001000, 6'b010000, 6'b001000.
